// File: rtl/ibwt_pkg.sv
// Shared types and constants for the inverse BWT decoder.
package ibwt_pkg;

   typedef enum logic [2:0] {IDLE, LOAD, CUM, WALK, EMIT} state_t;

   localparam int         ALPHABET     = 256;
   localparam logic [7:0] SENTINEL_DEF = 8'h24;

   // Width able to hold any per-char count 0..n
   function automatic int cnt_width(input int n);
      return $clog2(n + 1);
   endfunction

endpackage

// File: rtl/ibwt_if.sv
// Char stream bus of the inverse BWT decoder; err exists only with IBWT_ERR_CHECK_EN.
interface ibwt_if;
   logic       start;
   logic [7:0] input_string_char;
   logic       ready;
   logic [7:0] output_string_char;
   logic       valid_out;
   logic       busy;
`ifdef IBWT_ERR_CHECK_EN
   logic       err;
   modport master (output start, input_string_char,
                   input  ready, output_string_char, valid_out, busy, err);
   modport slave  (input  start, input_string_char,
                   output ready, output_string_char, valid_out, busy, err);
`else
   modport master (output start, input_string_char,
                   input  ready, output_string_char, valid_out, busy);
   modport slave  (input  start, input_string_char,
                   output ready, output_string_char, valid_out, busy);
`endif
endinterface

// File: rtl/ibwt_cum_count.sv
// 256-bin occurrence table: counts during LOAD, becomes the exclusive prefix C[] during CUM,
// and is read combinationally during WALK.
module ibwt_cum_count
   import ibwt_pkg::*;
#(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         inc_en,
   input  logic [7:0]   inc_sym,
   output logic [W-1:0] inc_old,
   input  logic         cum_en,
   output logic         cum_done,
   input  logic [7:0]   rd_sym,
   output logic [W-1:0] rd_val
);

   logic [W-1:0] tbl [ALPHABET];
   logic [7:0]   idx;
   logic [W-1:0] sum;

   assign inc_old  = tbl[inc_sym];
   assign rd_val   = tbl[rd_sym];
   // idx only leaves zero while sweeping, so this is high exactly in the last CUM cycle
   assign cum_done = (idx == 8'hFF);

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         for (int j = 0; j < ALPHABET; j++) tbl[j] <= '0;
         idx <= '0;
         sum <= '0;
      end else if (inc_en) begin
         tbl[inc_sym] <= tbl[inc_sym] + W'(1);
      end else if (cum_en) begin
         tbl[idx] <= sum;
         sum      <= sum + tbl[idx];
         idx      <= idx + 8'd1;
      end
   end

endmodule

// File: rtl/ibwt_decoder.sv
// Inverse BWT via LF-mapping: LOAD ranks, CUM prefix sums, WALK table, EMIT forward.
// Optional IBWT_ERR_CHECK_EN adds err and rejects strings without exactly one sentinel.
module ibwt_decoder
   import ibwt_pkg::*;
#(
   parameter int         STRING_LEN = 128,
   parameter logic [7:0] SENTINEL   = SENTINEL_DEF
) (
   input logic   clk,
   input logic   rst,
   ibwt_if.slave bus
);

   localparam int            W    = cnt_width(STRING_LEN);
   localparam int            AW   = $clog2(STRING_LEN);
   localparam logic [AW-1:0] LAST = AW'(STRING_LEN - 1);

   state_t        state, state_n;
   logic [AW-1:0] idx, k, p, e, ld_pos, wr_idx;
   logic [7:0]    l_mem    [STRING_LEN];
   logic [W-1:0]  rank_mem [STRING_LEN];
   logic [7:0]    out_buf  [STRING_LEN];
   logic          accept, cum_en, cum_done, clr, abort;
   logic [W-1:0]  inc_old, rd_val;
   logic [7:0]    rd_sym, walk_c;
   logic [7:0]    out_char;
   logic          valid_q;

   ibwt_cum_count #(.W(W)) u_cnt (
      .clk      (clk),
      .rst      (rst),
      .clr      (clr),
      .inc_en   (accept),
      .inc_sym  (bus.input_string_char),
      .inc_old  (inc_old),
      .cum_en   (cum_en),
      .cum_done (cum_done),
      .rd_sym   (rd_sym),
      .rd_val   (rd_val)
   );

   assign ld_pos = (state == IDLE) ? '0 : idx;
   assign walk_c = l_mem[p];
   // Outside WALK the read port watches the sentinel bin for the malformed-input check
   assign rd_sym = (state == WALK) ? walk_c : SENTINEL;
   // Sentinel is found last and lands at the end; all others fill from the back
   assign wr_idx = (k == LAST) ? LAST : AW'(STRING_LEN - 2) - k;

   assign bus.ready              = (state == IDLE) || (state == LOAD);
   assign bus.busy               = (state != IDLE);
   assign bus.valid_out          = valid_q;
   assign bus.output_string_char = out_char;

`ifdef IBWT_ERR_CHECK_EN
   logic chk;
   assign abort = chk && (rd_val != W'(1));

   always_ff @(posedge clk) begin
      if (rst) begin
         chk     <= 1'b0;
         bus.err <= 1'b0;
      end else begin
         chk <= (state == LOAD) && (state_n == CUM);
         if (abort)                          bus.err <= 1'b1;
         else if (accept && state == IDLE)   bus.err <= 1'b0;
      end
   end
`else
   assign abort = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_n;
   end

   always_comb begin
      state_n = state;
      accept  = 1'b0;
      cum_en  = 1'b0;
      clr     = 1'b0;
      unique case (state)
         IDLE: if (bus.start) begin
            accept  = 1'b1;
            state_n = LOAD;
         end
         LOAD: if (bus.start) begin
            accept = 1'b1;
            if (idx == LAST) state_n = CUM;
         end
         CUM: if (abort) begin
            clr     = 1'b1;
            state_n = IDLE;
         end else begin
            cum_en = 1'b1;
            if (cum_done) state_n = WALK;
         end
         WALK: if (k == LAST) state_n = EMIT;
         EMIT: begin
            clr = 1'b1;
            if (e == LAST) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         idx      <= '0;
         k        <= '0;
         p        <= '0;
         e        <= '0;
         valid_q  <= 1'b0;
         out_char <= '0;
      end else begin
         valid_q <= (state == EMIT);
         if (accept) idx <= ld_pos + AW'(1);
         if (state != WALK) begin
            k <= '0;
            p <= '0;
         end else begin
            k <= k + AW'(1);
            p <= AW'(rd_val + rank_mem[p]);
         end
         if (state != EMIT) begin
            e <= '0;
         end else begin
            e        <= e + AW'(1);
            out_char <= out_buf[e];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         l_mem[ld_pos]    <= bus.input_string_char;
         rank_mem[ld_pos] <= inc_old;
      end
      if (state == WALK) out_buf[wr_idx] <= walk_c;
   end

endmodule

// File: tb/tb_ibwt_decoder.sv
// Round-trip bench: forward BWT by sorted rotations, per-cycle compare of three decoder sizes.
module tb_ibwt_decoder;
   import ibwt_pkg::*;

   typedef logic [7:0] q8_t [$];

   logic       clk = 1'b0;
   logic       rst_s   [3];
   logic       start_s [3];
   logic [7:0] ch_s    [3];
   logic       vo [3], rdy [3], bsy [3];
   logic [7:0] oc [3];

   int   checks   = 0;
   int   failures = 0;
   int   cyc      = 0;
   int   exp_st [3] = '{-100000, -100000, -100000};
   q8_t  exp_str [3];
   q8_t  cap [3];
   bit   cmp_en = 1'b0;
   q8_t  none;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   ibwt_if b0 ();
   ibwt_if b1 ();
   ibwt_if b2 ();

   assign b0.start = start_s[0];  assign b0.input_string_char = ch_s[0];
   assign b1.start = start_s[1];  assign b1.input_string_char = ch_s[1];
   assign b2.start = start_s[2];  assign b2.input_string_char = ch_s[2];
   assign vo[0] = b0.valid_out;  assign oc[0] = b0.output_string_char;
   assign vo[1] = b1.valid_out;  assign oc[1] = b1.output_string_char;
   assign vo[2] = b2.valid_out;  assign oc[2] = b2.output_string_char;
   assign rdy[0] = b0.ready;  assign bsy[0] = b0.busy;
   assign rdy[1] = b1.ready;  assign bsy[1] = b1.busy;
   assign rdy[2] = b2.ready;  assign bsy[2] = b2.busy;

   ibwt_decoder #(.STRING_LEN(7))   u0 (.clk(clk), .rst(rst_s[0]), .bus(b0));
   ibwt_decoder #(.STRING_LEN(4))   u1 (.clk(clk), .rst(rst_s[1]), .bus(b1));
   ibwt_decoder #(.STRING_LEN(128)) u2 (.clk(clk), .rst(rst_s[2]), .bus(b2));

   function automatic int nl(input int d);
      case (d)
         0:       return 7;
         1:       return 4;
         default: return 128;
      endcase
   endfunction

   function automatic q8_t s2q(input string s);
      q8_t q;
      for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
      return q;
   endfunction

   function automatic bit rot_lt(input q8_t t, input int a, input int b);
      int n;
      n = t.size();
      for (int j = 0; j < n; j++) begin
         logic [7:0] x, y;
         x = t[(a + j) % n];
         y = t[(b + j) % n];
         if (x < y) return 1'b1;
         if (x > y) return 1'b0;
      end
      return 1'b0;
   endfunction

   // Forward BWT: sort all rotations, take the last column
   function automatic q8_t bwt(input q8_t t);
      int  n;
      int  ix [$];
      q8_t l;
      n = t.size();
      for (int i = 0; i < n; i++) ix.push_back(i);
      for (int i = 0; i < n - 1; i++) begin
         int m, tmp;
         m = i;
         for (int j = i + 1; j < n; j++) if (rot_lt(t, ix[j], ix[m])) m = j;
         tmp = ix[i]; ix[i] = ix[m]; ix[m] = tmp;
      end
      for (int r = 0; r < n; r++) l.push_back(t[(ix[r] + n - 1) % n]);
      return l;
   endfunction

   function automatic q8_t rand_text(input int n);
      q8_t q;
      for (int i = 0; i < n - 1; i++) q.push_back(8'($urandom_range(8'h25, 8'hFF)));
      q.push_back(8'h24);
      return q;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
      checks++;
      if (act !== want) begin
         failures++;
         $display("FAIL %s got=%0h want=%0h at cyc %0d", nm, act, want, cyc);
      end
   endtask

   task automatic chk_str(input string nm, input q8_t got, input q8_t want);
      chk({nm, "_len"}, got.size(), want.size());
      for (int i = 0; i < want.size() && i < got.size(); i++) chk(nm, got[i], want[i]);
   endtask

   task automatic feed(input int d, input q8_t s, input q8_t txt, input bit has_out,
                       input int gap_after, input int gap_len, output int last);
      cap[d].delete();
      last = cyc;
      for (int i = 0; i < s.size(); i++) begin
         @(negedge clk);
         chk("ready_load", rdy[d], 1);
         start_s[d] = 1'b1;
         ch_s[d]    = s[i];
         last       = cyc;
         if (i == gap_after) repeat (gap_len) begin
            @(negedge clk);
            start_s[d] = 1'b0;
            ch_s[d]    = 8'($urandom);
         end
      end
      @(negedge clk);
      start_s[d] = 1'b0;
      if (has_out) begin
         exp_str[d] = txt;
         exp_st[d]  = last + 258 + s.size();
      end
   endtask

   task automatic wait_out(input int d);
      int n;
      n = 0;
      while (n < 3000 && !(cyc >= exp_st[d] + nl(d) && bsy[d] === 1'b0)) begin
         @(negedge clk);
         n++;
      end
      chk("wait_out_bound", n < 3000, 1);
      exp_st[d] = -100000;
   endtask

   task automatic junk(input int d);
      int n;
      n = 0;
      while (n < 2000) begin
         @(negedge clk);
         n++;
         if (rdy[d]) break;
         start_s[d] = 1'($urandom);
         ch_s[d]    = 8'($urandom);
      end
      start_s[d] = 1'b0;
      chk("junk_bound", n < 2000, 1);
   endtask

   // Every cycle: valid_out must match the expected window and chars must match the text
   always @(negedge clk) begin : cmp
      logic ev;
      if (cmp_en) begin
         for (int d = 0; d < 3; d++) begin
            ev = (cyc >= exp_st[d]) && (cyc < exp_st[d] + nl(d));
            chk("valid_out", vo[d], ev);
            if (ev) chk("out_char", oc[d], exp_str[d][cyc - exp_st[d]]);
            if (vo[d] === 1'b1) cap[d].push_back(oc[d]);
         end
      end
   end

   initial begin
      int  last, n;
      q8_t t;
      for (int d = 0; d < 3; d++) begin
         rst_s[d] = 1'b1; start_s[d] = 1'b0; ch_s[d] = 8'h00;
      end
      repeat (3) @(negedge clk);
      for (int d = 0; d < 3; d++) rst_s[d] = 1'b0;
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
         chk("rst_ready", rdy[d], 1);
         chk("rst_busy", bsy[d], 0);
         chk("rst_valid", vo[d], 0);
         chk("rst_char", oc[d], 0);
      end
`ifdef IBWT_ERR_CHECK_EN
      chk("rst_err", b1.err, 0);
`endif
      cmp_en = 1'b1;

      // Pin the reference model with hand-computed transforms
      chk_str("model_banana", bwt(s2q("banana$")), s2q("annb$aa"));
      chk_str("model_aaa", bwt(s2q("aaa$")), s2q("aaa$"));

      // banana, back-to-back, with literal latency
      feed(0, s2q("annb$aa"), s2q("banana$"), 1'b1, -1, 0, last);
      n = 0;
      while (n < 1000 && vo[0] !== 1'b1) begin @(negedge clk); n++; end
      chk("first_valid_latency", cyc - last, 265);
      wait_out(0);
      chk_str("banana", cap[0], s2q("banana$"));

      // 3-cycle gap after char 1
      feed(1, s2q("aaa$"), s2q("aaa$"), 1'b1, 1, 3, last);
      wait_out(1);
      chk_str("aaa_gap", cap[1], s2q("aaa$"));

      // strobes while not ready, then a second string straight after
      feed(0, s2q("annb$aa"), s2q("banana$"), 1'b1, -1, 0, last);
      junk(0);
      wait_out(0);
      chk_str("banana_junk", cap[0], s2q("banana$"));
      feed(0, s2q("annb$aa"), s2q("banana$"), 1'b1, -1, 0, last);
      wait_out(0);
      chk_str("banana_again", cap[0], s2q("banana$"));

      // reset in the middle of WALK
      feed(0, s2q("annb$aa"), s2q("banana$"), 1'b1, -1, 0, last);
      while (cyc < last + 260) @(negedge clk);
      rst_s[0]  = 1'b1;
      exp_st[0] = -100000;
      @(negedge clk);
      rst_s[0] = 1'b0;
      chk("walk_rst_ready", rdy[0], 1);
      chk("walk_rst_busy", bsy[0], 0);
      chk("walk_rst_valid", vo[0], 0);
      repeat (300) @(negedge clk);
      chk("walk_rst_no_output", cap[0].size(), 0);
      feed(0, s2q("annb$aa"), s2q("banana$"), 1'b1, -1, 0, last);
      wait_out(0);
      chk_str("banana_after_rst", cap[0], s2q("banana$"));

      // randomized round trips
      for (int r = 0; r < 5; r++) begin
         t = rand_text(7);
         feed(0, bwt(t), t, 1'b1, -1, 0, last);
         wait_out(0);
         chk_str("rand7", cap[0], t);
         t = rand_text(4);
         feed(1, bwt(t), t, 1'b1, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), last);
         wait_out(1);
         chk_str("rand4", cap[1], t);
      end
      for (int r = 0; r < 2; r++) begin
         t = rand_text(128);
         feed(2, bwt(t), t, 1'b1, int'($urandom_range(0, 126)), int'($urandom_range(0, 4)), last);
         wait_out(2);
         chk_str("rand128", cap[2], t);
      end

`ifdef IBWT_ERR_CHECK_EN
      feed(1, s2q("aa$$"), none, 1'b0, -1, 0, last);
      @(negedge clk);
      @(negedge clk);
      chk("err_set", b1.err, 1);
      chk("err_busy", bsy[1], 0);
      chk("err_ready", rdy[1], 1);
      repeat (300) @(negedge clk);
      chk("err_hold", b1.err, 1);
      chk("err_no_output", cap[1].size(), 0);
      feed(1, s2q("aaa$"), s2q("aaa$"), 1'b1, -1, 0, last);
      chk("err_clear", b1.err, 0);
      wait_out(1);
      chk_str("after_err", cap[1], s2q("aaa$"));
`endif

      repeat (5) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
